track_video_driver: RTL and testbench
=====================================

TRACK_VIDEO_DRIVER -- requirements
Module: track_video_driver

Interface
REQ-001 The module SHALL have parameter H_ACTIVE, default 1280: active pixels per line.
REQ-002 The module SHALL have parameter H_FP, default 110: horizontal front porch, in pixels.
REQ-003 The module SHALL have parameter H_SYNC, default 40: horizontal sync width, in pixels.
REQ-004 The module SHALL have parameter H_BP, default 220: horizontal back porch, in pixels; H_TOTAL = 1650.
REQ-005 The module SHALL have parameter V_ACTIVE, default 720: active lines per frame.
REQ-006 The module SHALL have parameter V_FP, default 5: vertical front porch, in lines.
REQ-007 The module SHALL have parameter V_SYNC, default 5: vertical sync width, in lines.
REQ-008 The module SHALL have parameter V_BP, default 20: vertical back porch, in lines; V_TOTAL = 750.
REQ-009 The module SHALL have parameter PIXEL_LATENCY, default 2, legal range 1..8: cycles from hcount_out/vcount_out to the matching pixel_in.
REQ-010 clk_in  input  1  pixel clock.
REQ-011 rst_n_in  input  1  asynchronous, active-low reset.
REQ-012 hcount_out  output  11  horizontal position presented to the pixel renderer.
REQ-013 vcount_out  output  10  vertical position presented to the pixel renderer.
REQ-014 pixel_in  input  12  renderer colour {r4,g4,b4} for the position issued PIXEL_LATENCY cycles earlier.
REQ-015 rgb_out  output  12  aligned, blank-gated colour.
REQ-016 hsync_out  output  1  active-high horizontal sync, aligned with rgb_out.
REQ-017 vsync_out  output  1  active-high vertical sync, aligned with rgb_out.
REQ-018 active_out  output  1  aligned active-video flag.
REQ-019 new_frame_out  output  1  single-cycle pulse at start of vertical blanking (unaligned; for game logic).
REQ-020 frame_count_out  output  6  frame counter.

Function
REQ-021 hcount_out SHALL increment by 1 every cycle and wrap H_TOTAL-1 -> 0.
REQ-022 vcount_out SHALL increment by 1 only on an hcount wrap, and SHALL wrap V_TOTAL-1 -> 0.
REQ-023 At (H_TOTAL-1, V_TOTAL-1), both counters SHALL return to 0 on the same edge.
REQ-024 frame_count_out SHALL increment on the edge where both counters wrap together, and SHALL wrap 63 -> 0.
REQ-025 Undelayed active SHALL be (hcount < H_ACTIVE) AND (vcount < V_ACTIVE).
REQ-026 Undelayed hsync SHALL be high for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. [1390,1429].
REQ-027 Undelayed vsync SHALL be high for vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. [725,729], for whole lines.
REQ-028 Undelayed active, hsync and vsync SHALL pass through a shift pipeline of depth PIXEL_LATENCY+1.
REQ-029 rgb_out SHALL be registered as pixel_in when the pipeline stage aligned with pixel_in (depth PIXEL_LATENCY) is active, and 12'h000 otherwise.
REQ-030 Total latency from a counter value to its rgb_out, hsync_out, vsync_out and active_out SHALL be exactly PIXEL_LATENCY+1 cycles.
REQ-031 new_frame_out SHALL be high for exactly one cycle, while hcount_out == H_ACTIVE and vcount_out == V_ACTIVE.
REQ-032 new_frame_out SHALL NOT pass through the delay pipeline.
REQ-033 Behaviour for pixel_in SHALL be independent of its value during blanking; blanking output is always black.

Reset
REQ-034 On rst_n_in low, asynchronously: hcount_out=0, vcount_out=0, frame_count_out=0, all pipeline stages=0, rgb_out=0, hsync_out=0, vsync_out=0, active_out=0, new_frame_out=0.
REQ-035 On the first rising edge after rst_n_in deasserts, hcount_out SHALL become 1, since counting starts from (0,0).
REQ-036 Reset asserted mid-frame SHALL abort the frame with no sync glitch beyond forcing syncs low; frame_count_out SHALL NOT increment.

Verification
REQ-037 Release reset, PIXEL_LATENCY=2, pixel_in = {hcount[3:0], vcount[3:0], 4'hA} modelled with 2-cycle delay -> rgb_out equals the model for (h,v) exactly 3 cycles after issue for all active pixels of one frame.
REQ-038 Run a full frame -> hsync_out high for 40 cycles per line starting 3 cycles after hcount=1390; vsync_out high for 5x1650 cycles; 1280x720 cycles with active_out=1.
REQ-039 Drive pixel_in=12'hFFF constantly -> rgb_out = 0 whenever active_out=0.
REQ-040 Run 64 frames -> frame_count_out returns to 0, new_frame_out pulses exactly 64 times, each at (1280,720).
REQ-041 Assert rst_n_in at (700,300) mid-frame, asynchronously between edges -> all outputs 0 immediately; after release, counting restarts from (0,0) and frame_count_out remains 0.
REQ-042 Check the counter wrap at (1649,749) -> next cycle shows (0,0) and frame_count_out incremented by 1.

Source files
------------

// File: rtl/track_video_if.sv
// Video timing bundle between the track video driver, its pixel renderer and the display sink.
// Widths are fixed by the 1650x750 timing family: 11-bit h, 10-bit v, 12-bit {r4,g4,b4}.
interface track_video_if;
  logic [10:0] hcount_out;
  logic [9:0]  vcount_out;
  logic [11:0] pixel_in;
  logic [11:0] rgb_out;
  logic        hsync_out;
  logic        vsync_out;
  logic        active_out;
  logic        new_frame_out;
  logic [5:0]  frame_count_out;

  modport master (
    output hcount_out, vcount_out, rgb_out, hsync_out, vsync_out,
    output active_out, new_frame_out, frame_count_out,
    input  pixel_in
  );

  modport slave (
    input  hcount_out, vcount_out, rgb_out, hsync_out, vsync_out,
    input  active_out, new_frame_out, frame_count_out,
    output pixel_in
  );
endinterface

// File: rtl/track_video_driver.sv
// Raster timing generator: issues (h,v) to a renderer, then realigns the returned colour with
// delayed active/sync flags so rgb, hsync, vsync and active leave together.
module track_video_driver #(
  parameter int H_ACTIVE      = 1280,
  parameter int H_FP          = 110,
  parameter int H_SYNC        = 40,
  parameter int H_BP          = 220,
  parameter int V_ACTIVE      = 720,
  parameter int V_FP          = 5,
  parameter int V_SYNC        = 5,
  parameter int V_BP          = 20,
  parameter int PIXEL_LATENCY = 2
) (
  input  logic           clk_in,
  input  logic           rst_n_in,
  track_video_if.master  vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT      = 11'(H_ACTIVE);
  localparam logic [10:0] HS_FIRST   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_LAST    = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_FIRST   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Colour is forced black outside active video, whatever the renderer returns.
  function automatic logic [11:0] blank_gate(input logic active, input logic [11:0] pixel);
    return active ? pixel : 12'h000;
  endfunction

  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [5:0]  frame_count;
  logic        h_wrap;
  logic        v_wrap;

  assign h_wrap = (hcount == H_LAST);
  assign v_wrap = (vcount == V_LAST);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hcount      <= '0;
      vcount      <= '0;
      frame_count <= '0;
    end else begin
      hcount <= h_wrap ? 11'd0 : hcount + 11'd1;
      if (h_wrap) begin
        vcount <= v_wrap ? 10'd0 : vcount + 10'd1;
        if (v_wrap)
          frame_count <= frame_count + 6'd1;
      end
    end
  end

  // Stage p0: undelayed decode of the current counter position
  logic active_p0;
  logic hsync_p0;
  logic vsync_p0;

  assign active_p0 = (hcount < H_ACT) && (vcount < V_ACT);
  assign hsync_p0  = (hcount >= HS_FIRST) && (hcount <= HS_LAST);
  assign vsync_p0  = (vcount >= VS_FIRST) && (vcount <= VS_LAST);

  // Stages p1..p(L+1): bit k carries the decode from k+1 cycles ago
  logic [PIXEL_LATENCY:0] active_pipe;
  logic [PIXEL_LATENCY:0] hsync_pipe;
  logic [PIXEL_LATENCY:0] vsync_pipe;
  logic [11:0]            rgb_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      active_pipe <= '0;
      hsync_pipe  <= '0;
      vsync_pipe  <= '0;
      rgb_q       <= 12'h000;
    end else begin
      active_pipe <= {active_pipe[PIXEL_LATENCY-1:0], active_p0};
      hsync_pipe  <= {hsync_pipe[PIXEL_LATENCY-1:0],  hsync_p0};
      vsync_pipe  <= {vsync_pipe[PIXEL_LATENCY-1:0],  vsync_p0};
      // pixel_in belongs to the position issued PIXEL_LATENCY cycles ago
      rgb_q       <= blank_gate(active_pipe[PIXEL_LATENCY-1], vid.pixel_in);
    end
  end

  assign vid.hcount_out      = hcount;
  assign vid.vcount_out      = vcount;
  assign vid.frame_count_out = frame_count;
  assign vid.rgb_out         = rgb_q;
  assign vid.active_out      = active_pipe[PIXEL_LATENCY];
  assign vid.hsync_out       = hsync_pipe[PIXEL_LATENCY];
  assign vid.vsync_out       = vsync_pipe[PIXEL_LATENCY];
  // Game-logic strobe, deliberately taken straight from the counters
  assign vid.new_frame_out   = (hcount == H_ACT) && (vcount == V_ACT);

endmodule

// File: tb/tb_track_video_driver.sv
// Bench for track_video_driver on a scaled-down raster so that 64 frames stay short.
// Expected values come from cycle-count arithmetic on the raster rules.
module tb_track_video_driver;
  localparam int HA = 16, HFP = 3, HS = 4, HBP = 5;
  localparam int VA = 10, VFP = 2, VS = 2, VBP = 3;
  localparam int LAT = 2;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FT = HT * VT;
  localparam int DLY = LAT + 1;

  logic clk_in = 1'b0;
  logic rst_n_in = 1'b0;
  track_video_if vid();

  track_video_driver #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .PIXEL_LATENCY(LAT)
  ) dut (
    .clk_in(clk_in),
    .rst_n_in(rst_n_in),
    .vid(vid)
  );

  always #5 clk_in = ~clk_in;

  int cmp_cnt = 0;
  int bad_cnt = 0;
  int n = 0;                 // cycles since reset release; n=0 shows position (0,0)
  logic [11:0] last_pix = '0;

  function automatic int pos_h(int c); return c % HT; endfunction
  function automatic int pos_v(int c); return (c / HT) % VT; endfunction
  function automatic int frame_of(int c); return (c / FT) % 64; endfunction

  function automatic bit exp_active(int c);
    if (c < DLY) return 1'b0;
    return (pos_h(c - DLY) < HA) && (pos_v(c - DLY) < VA);
  endfunction
  function automatic bit exp_hsync(int c);
    if (c < DLY) return 1'b0;
    return (pos_h(c - DLY) >= HA + HFP) && (pos_h(c - DLY) < HA + HFP + HS);
  endfunction
  function automatic bit exp_vsync(int c);
    if (c < DLY) return 1'b0;
    return (pos_v(c - DLY) >= VA + VFP) && (pos_v(c - DLY) < VA + VFP + VS);
  endfunction
  function automatic bit exp_new_frame(int c);
    return (pos_h(c) == HA) && (pos_v(c) == VA);
  endfunction
  function automatic logic [11:0] pattern(int c);
    return {4'(pos_h(c)), 4'(pos_v(c)), 4'hA};
  endfunction
  // Renderer: pattern for active positions issued LAT cycles ago, noise in blanking
  function automatic logic [11:0] render(int c);
    if (c >= LAT && pos_h(c - LAT) < HA && pos_v(c - LAT) < VA) return pattern(c - LAT);
    return 12'($urandom);
  endfunction

  task automatic advance(input logic [11:0] p);
    vid.pixel_in = p;
    last_pix = p;
    @(negedge clk_in);
    n++;
  endtask

  task automatic do_reset();
    rst_n_in = 1'b0;
    vid.pixel_in = '0;
    repeat (3) @(negedge clk_in);
    rst_n_in = 1'b1;
    n = 0;
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0;
    vid.pixel_in = 12'hFFF;
    @(negedge clk_in);
    cmp_cnt++; if (vid.hcount_out !== 11'd0) begin bad_cnt++; $display("FAIL reset_hcount got %0d exp 0", vid.hcount_out); end
    cmp_cnt++; if (vid.vcount_out !== 10'd0) begin bad_cnt++; $display("FAIL reset_vcount got %0d exp 0", vid.vcount_out); end
    cmp_cnt++; if (vid.frame_count_out !== 6'd0) begin bad_cnt++; $display("FAIL reset_frame got %0d exp 0", vid.frame_count_out); end
    cmp_cnt++; if (vid.rgb_out !== 12'h000) begin bad_cnt++; $display("FAIL reset_rgb got %h exp 000", vid.rgb_out); end
    cmp_cnt++; if ({vid.hsync_out, vid.vsync_out, vid.active_out, vid.new_frame_out} !== 4'b0000) begin
      bad_cnt++; $display("FAIL reset_flags got %b exp 0000", {vid.hsync_out, vid.vsync_out, vid.active_out, vid.new_frame_out});
    end
    rst_n_in = 1'b1;
    n = 0;
    advance(render(0));
    cmp_cnt++; if (vid.hcount_out !== 11'd1) begin bad_cnt++; $display("FAIL first_edge_hcount got %0d exp 1", vid.hcount_out); end
    cmp_cnt++; if (vid.vcount_out !== 10'd0) begin bad_cnt++; $display("FAIL first_edge_vcount got %0d exp 0", vid.vcount_out); end
  endtask

  task automatic test_frame_alignment();
    int hs_cnt = 0, vs_cnt = 0, act_cnt = 0;
    logic [11:0] exp_rgb;
    do_reset();
    for (int k = 0; k < FT + DLY; k++) begin
      cmp_cnt++; if (vid.hcount_out !== 11'(pos_h(n)) || vid.vcount_out !== 10'(pos_v(n))) begin
        bad_cnt++; $display("FAIL pos n=%0d got (%0d,%0d) exp (%0d,%0d)", n, vid.hcount_out, vid.vcount_out, pos_h(n), pos_v(n));
      end
      cmp_cnt++; if ({vid.active_out, vid.hsync_out, vid.vsync_out} !== {exp_active(n), exp_hsync(n), exp_vsync(n)}) begin
        bad_cnt++; $display("FAIL flags n=%0d got %b exp %b", n, {vid.active_out, vid.hsync_out, vid.vsync_out},
                            {exp_active(n), exp_hsync(n), exp_vsync(n)});
      end
      exp_rgb = exp_active(n) ? pattern(n - DLY) : 12'h000;
      cmp_cnt++; if (vid.rgb_out !== exp_rgb) begin
        bad_cnt++; $display("FAIL rgb_align n=%0d got %h exp %h", n, vid.rgb_out, exp_rgb);
      end
      if (n >= DLY) begin
        hs_cnt += int'(vid.hsync_out);
        vs_cnt += int'(vid.vsync_out);
        act_cnt += int'(vid.active_out);
      end
      advance(render(n));
    end
    cmp_cnt++; if (hs_cnt != HS * VT) begin bad_cnt++; $display("FAIL hsync_cycles got %0d exp %0d", hs_cnt, HS * VT); end
    cmp_cnt++; if (vs_cnt != VS * HT) begin bad_cnt++; $display("FAIL vsync_cycles got %0d exp %0d", vs_cnt, VS * HT); end
    cmp_cnt++; if (act_cnt != HA * VA) begin bad_cnt++; $display("FAIL active_cycles got %0d exp %0d", act_cnt, HA * VA); end
  endtask

  task automatic test_blank_black();
    logic [11:0] exp_rgb;
    advance(12'hFFF);
    for (int k = 0; k < FT; k++) begin
      exp_rgb = exp_active(n) ? 12'hFFF : 12'h000;
      cmp_cnt++; if (vid.rgb_out !== exp_rgb) begin
        bad_cnt++; $display("FAIL blank_white n=%0d got %h exp %h", n, vid.rgb_out, exp_rgb);
      end
      if (vid.active_out === 1'b0) begin
        cmp_cnt++; if (vid.rgb_out !== 12'h000) begin
          bad_cnt++; $display("FAIL blank_black n=%0d got %h exp 000", n, vid.rgb_out);
        end
      end
      advance(12'hFFF);
    end
  endtask

  task automatic test_random_pixels();
    logic [11:0] exp_rgb;
    advance(12'($urandom));
    for (int k = 0; k < FT; k++) begin
      exp_rgb = exp_active(n) ? last_pix : 12'h000;
      cmp_cnt++; if (vid.rgb_out !== exp_rgb || vid.active_out !== exp_active(n)) begin
        bad_cnt++; $display("FAIL random_rgb n=%0d got %h/%b exp %h/%b", n, vid.rgb_out, vid.active_out, exp_rgb, exp_active(n));
      end
      advance(12'($urandom));
    end
  endtask

  task automatic test_frames_64();
    int pulses = 0;
    do_reset();
    for (int k = 0; k < 64 * FT; k++) begin
      cmp_cnt++; if (vid.frame_count_out !== 6'(frame_of(n)) || vid.new_frame_out !== exp_new_frame(n)) begin
        bad_cnt++; $display("FAIL frame_seq n=%0d got fc=%0d nf=%b exp fc=%0d nf=%b", n, vid.frame_count_out,
                            vid.new_frame_out, frame_of(n), exp_new_frame(n));
      end
      if (vid.new_frame_out === 1'b1) begin
        pulses++;
        cmp_cnt++; if (vid.hcount_out !== 11'(HA) || vid.vcount_out !== 10'(VA)) begin
          bad_cnt++; $display("FAIL new_frame_pos got (%0d,%0d) exp (%0d,%0d)", vid.hcount_out, vid.vcount_out, HA, VA);
        end
      end
      advance(12'($urandom));
    end
    cmp_cnt++; if (pulses != 64) begin bad_cnt++; $display("FAIL new_frame_count got %0d exp 64", pulses); end
    cmp_cnt++; if (vid.frame_count_out !== 6'd0) begin bad_cnt++; $display("FAIL frame_wrap64 got %0d exp 0", vid.frame_count_out); end
  endtask

  task automatic test_wrap();
    do_reset();
    while (n < FT - 1) advance(render(n));
    cmp_cnt++; if (vid.hcount_out !== 11'(HT - 1) || vid.vcount_out !== 10'(VT - 1) || vid.frame_count_out !== 6'd0) begin
      bad_cnt++; $display("FAIL pre_wrap got (%0d,%0d,%0d) exp (%0d,%0d,0)", vid.hcount_out, vid.vcount_out,
                          vid.frame_count_out, HT - 1, VT - 1);
    end
    advance(render(n));
    cmp_cnt++; if (vid.hcount_out !== 11'd0 || vid.vcount_out !== 10'd0 || vid.frame_count_out !== 6'd1) begin
      bad_cnt++; $display("FAIL post_wrap got (%0d,%0d,%0d) exp (0,0,1)", vid.hcount_out, vid.vcount_out, vid.frame_count_out);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    while (n < FT + (VA / 2) * HT + HA / 2) advance(render(n));
    cmp_cnt++; if (vid.active_out !== 1'b1 || vid.frame_count_out !== 6'd1) begin
      bad_cnt++; $display("FAIL pre_abort got act=%b fc=%0d exp act=1 fc=1", vid.active_out, vid.frame_count_out);
    end
    vid.pixel_in = 12'hFFF;
    #2 rst_n_in = 1'b0;
    #1;
    cmp_cnt++; if (vid.hcount_out !== 11'd0 || vid.vcount_out !== 10'd0 || vid.frame_count_out !== 6'd0) begin
      bad_cnt++; $display("FAIL abort_counters got (%0d,%0d,%0d) exp (0,0,0)", vid.hcount_out, vid.vcount_out, vid.frame_count_out);
    end
    cmp_cnt++; if (vid.rgb_out !== 12'h000 || {vid.hsync_out, vid.vsync_out, vid.active_out, vid.new_frame_out} !== 4'b0000) begin
      bad_cnt++; $display("FAIL abort_outputs got rgb=%h flags=%b exp 000/0000", vid.rgb_out,
                          {vid.hsync_out, vid.vsync_out, vid.active_out, vid.new_frame_out});
    end
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    n = 0;
    for (int k = 0; k < 2 * HT; k++) begin
      cmp_cnt++; if (vid.hcount_out !== 11'(pos_h(n)) || vid.vcount_out !== 10'(pos_v(n)) || vid.frame_count_out !== 6'd0) begin
        bad_cnt++; $display("FAIL restart n=%0d got (%0d,%0d,%0d) exp (%0d,%0d,0)", n, vid.hcount_out, vid.vcount_out,
                            vid.frame_count_out, pos_h(n), pos_v(n));
      end
      cmp_cnt++; if ({vid.active_out, vid.hsync_out, vid.vsync_out} !== {exp_active(n), exp_hsync(n), exp_vsync(n)}) begin
        bad_cnt++; $display("FAIL restart_flags n=%0d got %b exp %b", n, {vid.active_out, vid.hsync_out, vid.vsync_out},
                            {exp_active(n), exp_hsync(n), exp_vsync(n)});
      end
      advance(render(n));
    end
  endtask

  initial begin
    vid.pixel_in = '0;
    test_reset();
    test_frame_alignment();
    test_blank_black();
    test_random_pixels();
    test_wrap();
    test_mid_reset();
    test_frames_64();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, bad_cnt);
    $finish;
  end
endmodule
